// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and size helpers for the line-granular memory responder.
//   - default parameter values for the responder and its storage array
//   - line_bytes / off_width / index_width derivations
//   - resp_state_t : single-outstanding responder states
//   - pend_entry_t : one in-flight read (used when MEM_PIPELINE_EN is defined)
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int WORD_SIZE_DEF = 32;
   localparam int LINE_SIZE_DEF = 128;
   localparam int MEM_LINES_DEF = 4096;
   // Wide enough for any practical MEM_LATENCY.
   localparam int COUNT_WIDTH   = 8;

   function automatic int line_bytes(input int line_size);
      return line_size / 8;
   endfunction

   // Number of byte-offset bits inside one line.
   function automatic int off_width(input int line_size);
      return $clog2(line_size / 8);
   endfunction

   // Number of address bits that select a line in the array.
   function automatic int index_width(input int mem_lines);
      return $clog2(mem_lines);
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } resp_state_t;

   // Address width is the default WORD_SIZE; the responder refuses other
   // widths when the pending queue is built.
   typedef struct packed {
      logic [WORD_SIZE_DEF-1:0] addr;
      logic [COUNT_WIDTH-1:0]   count;
   } pend_entry_t;

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// MEM_LINES x LINE_SIZE line store: synchronous write, combinational read.
// A write to the line being read in the same cycle is forwarded to rd_data,
// so a read registered at that edge sees the new line.
// Ports:
//   clk       in   clock
//   wr_en     in   write strobe, commits wr_data at the rising edge
//   wr_index  in   line index to write
//   wr_data   in   full line to write
//   rd_index  in   line index to read
//   rd_data   out  line at rd_index, or wr_data when writing that line
// -----------------------------------------------------------------------------
module mem_array
   import mem_pkg::*;
#(
   parameter int LINE_SIZE = LINE_SIZE_DEF,
   parameter int MEM_LINES = MEM_LINES_DEF,
   parameter int IDX_W     = index_width(MEM_LINES)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_index,
   input  logic [LINE_SIZE-1:0] wr_data,
   input  logic [IDX_W-1:0]     rd_index,
   output logic [LINE_SIZE-1:0] rd_data
);

   logic [LINE_SIZE-1:0] mem_q [MEM_LINES];

   // NOTE: the array has no reset; clearing thousands of lines would need a
   // reset port per row and memory contents are defined only by writes.
   // NOTE: sequential state uses non-blocking assignment so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_index] <= wr_data;
      end
   end

   always_comb begin
      if (wr_en && (wr_index == rd_index)) begin
         rd_data = wr_data;
      end else begin
         rd_data = mem_q[rd_index];
      end
   end

endmodule

// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
// Main-memory end of the line-granular cache/memory protocol. Accepts line
// reads (mem_req, held until answered) and one-cycle line write-backs, and
// returns whole lines on mem_res MEM_LATENCY cycles after acceptance.
// Build option: define MEM_PIPELINE_EN for an in-order queue of up to
// PEND_DEPTH in-flight reads; otherwise one read is outstanding at a time.
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-low reset
//   mem_req         in   read request, held until the matching mem_res
//   mem_req_addr    in   read address (line offset ignored)
//   mem_write       in   write-back strobe, one cycle per line
//   mem_write_addr  in   write-back address (line offset ignored)
//   mem_write_data  in   line to store
//   mem_res         out  one-cycle response pulse
//   mem_res_addr    out  line-aligned address of the returned line
//   mem_res_data    out  returned line (held while mem_res is low)
// -----------------------------------------------------------------------------
module memory_responder
   import mem_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int LINE_SIZE   = LINE_SIZE_DEF,
   parameter int MEM_LATENCY = 5,
   parameter int MEM_LINES   = MEM_LINES_DEF,
   parameter int PEND_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_req,
   input  logic [WORD_SIZE-1:0] mem_req_addr,
   input  logic                 mem_write,
   input  logic [WORD_SIZE-1:0] mem_write_addr,
   input  logic [LINE_SIZE-1:0] mem_write_data,
   output logic                 mem_res,
   output logic [WORD_SIZE-1:0] mem_res_addr,
   output logic [LINE_SIZE-1:0] mem_res_data
);

   localparam int OFF_W = off_width(LINE_SIZE);
   localparam int IDX_W = index_width(MEM_LINES);
   localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(line_bytes(LINE_SIZE) - 1);

   if (MEM_LATENCY < 1 || PEND_DEPTH < 1 || (LINE_SIZE % 8) != 0) begin : g_bad_params
      $error("memory_responder: illegal parameter combination");
   end

   logic [WORD_SIZE-1:0] req_line;
   logic [WORD_SIZE-1:0] rd_addr;
   logic [LINE_SIZE-1:0] rd_data;
   logic                 res_load;
   logic [WORD_SIZE-1:0] res_addr_q, res_addr_d;
   logic [LINE_SIZE-1:0] res_data_q, res_data_d;
   logic                 unused_wr_addr;

   assign req_line       = mem_req_addr & ~OFF_MASK;
   // Only the index bits of the write address select a line.
   assign unused_wr_addr = ^mem_write_addr;

   mem_array #(
      .LINE_SIZE (LINE_SIZE),
      .MEM_LINES (MEM_LINES),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk      (clk),
      .wr_en    (mem_write),
      .wr_index (mem_write_addr[OFF_W +: IDX_W]),
      .wr_data  (mem_write_data),
      .rd_index (rd_addr[OFF_W +: IDX_W]),
      .rd_data  (rd_data)
   );

   // Response registers load at the registration edge and hold otherwise.
   assign res_addr_d = res_load ? rd_addr : res_addr_q;
   assign res_data_d = res_load ? rd_data : res_data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_addr_q <= '0;
         res_data_q <= '0;
      end else begin
         res_addr_q <= res_addr_d;
         res_data_q <= res_data_d;
      end
   end

`ifdef MEM_PIPELINE_EN

   localparam int NUM_W = $clog2(PEND_DEPTH + 1);

   if (WORD_SIZE != WORD_SIZE_DEF) begin : g_bad_width
      $error("memory_responder: pending queue supports only the default WORD_SIZE");
   end

   // Entry 0 is the oldest read; entries at index >= num_q are empty.
   pend_entry_t      pend_q [PEND_DEPTH];
   pend_entry_t      pend_d [PEND_DEPTH];
   logic [NUM_W-1:0] num_q, num_d;
   logic             res_q;
   logic             hit, full, deq, enq, bypass;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_q <= '0;
         res_q <= 1'b0;
         for (int i = 0; i < PEND_DEPTH; i++) begin
            pend_q[i] <= '0;
         end
      end else begin
         num_q  <= num_d;
         res_q  <= res_load;
         pend_q <= pend_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      // A held request is already pending or is being answered this cycle.
      hit = res_q && (res_addr_q == req_line);
      for (int i = 0; i < PEND_DEPTH; i++) begin
         if ((NUM_W'(i) < num_q) && (pend_q[i].addr == req_line)) begin
            hit = 1'b1;
         end
      end
      full   = (num_q == NUM_W'(PEND_DEPTH));
      deq    = (num_q != '0) && (pend_q[0].count == '0);
      enq    = mem_req && !hit && (!full || deq);
      // With a one-cycle latency the read must register at its own
      // acceptance edge, so an empty queue is skipped entirely.
      bypass = (MEM_LATENCY == 1) && enq && (num_q == '0);

      res_load = deq || bypass;
      rd_addr  = bypass ? req_line : pend_q[0].addr;

      pend_d = pend_q;
      if (deq) begin
         for (int i = 0; i < PEND_DEPTH - 1; i++) begin
            pend_d[i] = pend_q[i + 1];
         end
      end
      num_d = num_q - NUM_W'(deq);
      for (int i = 0; i < PEND_DEPTH; i++) begin
         if (pend_d[i].count != '0) begin
            pend_d[i].count = pend_d[i].count - COUNT_WIDTH'(1);
         end
      end
      if (enq && !bypass) begin
         for (int i = 0; i < PEND_DEPTH; i++) begin
            if (NUM_W'(i) == num_d) begin
               pend_d[i].addr  = req_line;
               pend_d[i].count = COUNT_WIDTH'(MEM_LATENCY - 1);
            end
         end
         num_d = num_d + NUM_W'(1);
      end
   end

   always_comb begin
      mem_res      = res_q;
      mem_res_addr = res_addr_q;
      mem_res_data = res_data_q;
   end

`else

   resp_state_t            state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [WORD_SIZE-1:0]   line_q, line_d;

   // The array is read from the live request in IDLE (one-cycle latency
   // registers at the acceptance edge) and from the latched line otherwise.
   assign rd_addr = (state_q == IDLE) ? req_line : line_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      res_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_req) begin
               line_d = req_line;
               cnt_d  = COUNT_WIDTH'(MEM_LATENCY - 1);
               if (MEM_LATENCY == 1) begin
                  state_d  = RESP;
                  res_load = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d  = RESP;
               res_load = 1'b1;
            end else begin
               cnt_d = cnt_q - COUNT_WIDTH'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_res      = (state_q == RESP);
      mem_res_addr = res_addr_q;
      mem_res_data = res_data_q;
   end

`endif

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

   localparam int LAT = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_req;
   logic [31:0]  mem_req_addr;
   logic         mem_write;
   logic [31:0]  mem_write_addr;
   logic [127:0] mem_write_data;
   logic         mem_res;
   logic [31:0]  mem_res_addr;
   logic [127:0] mem_res_data;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] D_A5 = {16{8'hA5}};
   localparam logic [127:0] D_11 = {16{8'h11}};
   localparam logic [127:0] D_22 = {16{8'h22}};
   localparam logic [127:0] D_33 = {16{8'h33}};
   localparam logic [127:0] D_5A = {16{8'h5A}};
   localparam logic [127:0] D_66 = {16{8'h66}};
   localparam logic [127:0] D_77 = {16{8'h77}};

   memory_responder #(
      .WORD_SIZE   (32),
      .LINE_SIZE   (128),
      .MEM_LATENCY (LAT),
      .MEM_LINES   (4096),
      .PEND_DEPTH  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_req_addr   (mem_req_addr),
      .mem_write      (mem_write),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .mem_res        (mem_res),
      .mem_res_addr   (mem_res_addr),
      .mem_res_data   (mem_res_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic write_line(input logic [31:0] addr, input logic [127:0] data);
      mem_write      = 1'b1;
      mem_write_addr = addr;
      mem_write_data = data;
      @(posedge clk); #1;
      mem_write = 1'b0;
   endtask

   // Holds mem_req from the next edge (acceptance) until one edge past the
   // response. Optionally writes waddr/wdata so that it commits at edge
   // acceptance+wr_edge. lat = edges after acceptance when mem_res was seen.
   task automatic do_read(input logic [31:0] addr, input int wr_edge,
                          input logic [31:0] waddr, input logic [127:0] wdata,
                          output int lat, output logic [31:0] raddr,
                          output logic [127:0] rdata);
      mem_req      = 1'b1;
      mem_req_addr = addr;
      @(posedge clk); #1;
      mem_write = 1'b0;
      lat   = 0;
      raddr = '0;
      rdata = '0;
      for (int n = 1; n <= 20; n++) begin
         if (n == wr_edge) begin
            mem_write      = 1'b1;
            mem_write_addr = waddr;
            mem_write_data = wdata;
         end
         @(posedge clk); #1;
         mem_write = 1'b0;
         @(negedge clk);
         if (mem_res) begin
            lat   = n;
            raddr = mem_res_addr;
            rdata = mem_res_data;
            break;
         end
      end
      @(posedge clk); #1;
      mem_req = 1'b0;
   endtask

   task automatic count_pulses(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (mem_res) cnt++;
      end
      @(posedge clk); #1;
   endtask

`ifdef MEM_PIPELINE_EN
   task automatic run_pipeline_test();
      logic [31:0]  pa [4];
      logic [127:0] pd [4];
      int           rn [$];
      logic [31:0]  ra [$];
      logic [127:0] rdat [$];
      int           e_n;
      int           exp_n;
      logic [31:0]  exp_a;
      logic [127:0] exp_d;
      pa  = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 32'h0000_5000};
      pd  = '{D_A5, D_33, D_5A, D_77};
      e_n = -1;
      write_line(32'h0000_4000, D_66);
      for (int n = 0; n <= 16; n++) begin
         if (n < 4) begin
            mem_req      = 1'b1;
            mem_req_addr = pa[n];
         end else if (e_n < 0 || n <= e_n + 1) begin
            mem_req      = 1'b1;
            mem_req_addr = 32'h0000_4008;
         end else begin
            mem_req = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (mem_res) begin
            rn.push_back(n);
            ra.push_back(mem_res_addr);
            rdat.push_back(mem_res_data);
            if (mem_res_addr == 32'h0000_4000) e_n = n;
         end
      end
      mem_req = 1'b0;
      check("pipe_resp_count", 128'(rn.size()), 128'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < rn.size()) begin
            exp_n = (i < 4) ? LAT + i : 2 * LAT;
            exp_a = (i < 4) ? pa[i] : 32'h0000_4000;
            exp_d = (i < 4) ? pd[i] : D_66;
            check($sformatf("pipe_edge%0d", i), 128'(rn[i]), 128'(exp_n));
            check($sformatf("pipe_addr%0d", i), 128'(ra[i]), 128'(exp_a));
            check($sformatf("pipe_data%0d", i), rdat[i], exp_d);
         end
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      int           lat;
      int           cnt;
      logic [31:0]  raddr;
      logic [127:0] rdata;

      rst            = 1'b0;
      mem_req        = 1'b0;
      mem_req_addr   = '0;
      mem_write      = 1'b0;
      mem_write_addr = '0;
      mem_write_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("reset_res", 128'(mem_res), 128'(0));
      check("reset_addr", 128'(mem_res_addr), 128'(0));
      check("reset_data", mem_res_data, 128'(0));
      @(posedge clk); #1;

      // Latency and address alignment; the held request must not repeat.
      write_line(32'h0000_1000, D_A5);
      do_read(32'h0000_1004, 0, '0, '0, lat, raddr, rdata);
      check("lat_edges", 128'(lat), 128'(LAT));
      check("lat_addr", 128'(raddr), 128'(32'h0000_1000));
      check("lat_data", rdata, D_A5);
      count_pulses(10, cnt);
      check("held_no_dup", 128'(cnt), 128'(0));

      // Write and read of the same line in the accepting cycle.
      mem_write      = 1'b1;
      mem_write_addr = 32'h0000_2000;
      mem_write_data = D_11;
      do_read(32'h0000_2000, 0, '0, '0, lat, raddr, rdata);
      check("fwd_same_cycle_lat", 128'(lat), 128'(LAT));
      check("fwd_same_cycle_data", rdata, D_11);

      // Write during the wait, then a write on the registration edge.
      do_read(32'h0000_2000, 3, 32'h0000_2000, D_22, lat, raddr, rdata);
      check("fwd_wait_data", rdata, D_22);
      do_read(32'h0000_2000, LAT, 32'h0000_2000, D_33, lat, raddr, rdata);
      check("fwd_reg_edge_lat", 128'(lat), 128'(LAT));
      check("fwd_reg_edge_data", rdata, D_33);

      // A write to another line on the registration edge is not forwarded.
      do_read(32'h0000_1000, LAT, 32'h0000_5000, D_77, lat, raddr, rdata);
      check("fwd_other_line", rdata, D_A5);

      // High address bits alias onto the same line.
      write_line(32'h0001_0000, D_5A);
      do_read(32'h0000_0000, 0, '0, '0, lat, raddr, rdata);
      check("wrap_addr", 128'(raddr), 128'(32'h0000_0000));
      check("wrap_data", rdata, D_5A);
      do_read(32'h0001_0008, 0, '0, '0, lat, raddr, rdata);
      check("wrap_hi_addr", 128'(raddr), 128'(32'h0001_0000));
      check("wrap_hi_data", rdata, D_5A);

      // Reset in the middle of the wait discards the read.
      mem_req      = 1'b1;
      mem_req_addr = 32'h0000_3000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      check("midrst_res", 128'(mem_res), 128'(0));
      check("midrst_addr", 128'(mem_res_addr), 128'(0));
      check("midrst_data", mem_res_data, 128'(0));
      @(posedge clk); #1;
      mem_req = 1'b0;
      rst     = 1'b1;
      count_pulses(20, cnt);
      check("midrst_no_resp", 128'(cnt), 128'(0));

      // Array contents survive reset.
      do_read(32'h0000_1000, 0, '0, '0, lat, raddr, rdata);
      check("post_rst_lat", 128'(lat), 128'(LAT));
      check("post_rst_data", rdata, D_A5);

`ifdef MEM_PIPELINE_EN
      run_pipeline_test();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Main-memory end of the line-granular cache/memory protocol.
- Accepts line read requests (mem_req) and line write-backs (mem_write) from a data cache.
- Returns whole lines on the mem_res channel after a fixed latency.
- Sits below the cache stage; it is the memory model used for simulation and the basis for the later real controller.

Parameters:
- WORD_SIZE, 32, address width in bits.
- LINE_SIZE, 128, line width in bits; must be a multiple of 8 and a power of two.
- MEM_LATENCY, 5, cycles from request acceptance to response; must be >= 1.
- MEM_LINES, 4096, number of lines stored; must be a power of two.
- PEND_DEPTH, 4, in-flight read capacity; used only with MEM_PIPELINE_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_req  in  1  read request; the requester holds it high until the matching mem_res.
- mem_req_addr  in  WORD_SIZE  read address; the line offset is ignored.
- mem_write  in  1  write-back strobe, one cycle per line.
- mem_write_addr  in  WORD_SIZE  write-back address; the line offset is ignored.
- mem_write_data  in  LINE_SIZE  full line to store.
- mem_res  out  1  one-cycle response pulse.
- mem_res_addr  out  WORD_SIZE  line-aligned address of the returned line; the offset bits are zero.
- mem_res_data  out  LINE_SIZE  returned line.

Behaviour:
- Reset (rst low, asynchronous):
  - mem_res, mem_res_addr and mem_res_data go to 0; state goes to IDLE; pending reads are discarded.
  - Array contents are not reset.
  - Reset asserted mid-latency means no response is ever issued for that request.
- Line indexing:
  - OFF = log2(LINE_SIZE/8).
  - Line index = addr[OFF +: log2(MEM_LINES)].
  - Higher address bits are ignored, so accesses wrap modulo MEM_LINES.
- Writes:
  - Always accepted, with no backpressure.
  - Committed to the array at the rising edge where mem_write=1, in any state.
- FSM (without MEM_PIPELINE_EN):
  - IDLE: if mem_req=1, latch the line-aligned address, load counter = MEM_LATENCY-1, go to WAIT. A request sampled while the state is not IDLE is ignored; the requester keeps holding it.
  - WAIT: decrement the counter. At counter==0, go to RESP, registering mem_res_addr and mem_res_data at that edge.
  - RESP: mem_res=1 for exactly this cycle, then IDLE. A mem_req still high in this cycle is not sampled.
- Latency: a request accepted at edge t produces mem_res high during the cycle following edge t+MEM_LATENCY. With MEM_LATENCY=1, WAIT is skipped (IDLE goes directly to RESP).
- Read data source: the array value at the moment of registration. Exceptions:
  - A write to the same line in that same cycle is forwarded: mem_res_data = mem_write_data.
  - Writes to the line during WAIT are therefore visible in the response.
- Simultaneous read and write in IDLE to the same line: accepted normally; the response returns the new data.
- mem_res_addr and mem_res_data hold their last value when mem_res=0.

Optional Feature:
- MEM_PIPELINE_EN defined:
  - Reads are tracked in an in-order pending FIFO of PEND_DEPTH entries, each holding {line address, remaining cycles}.
  - A new mem_req is enqueued in any cycle when:
    - the FIFO is not full, and
    - its line address matches no pending entry and not the line being responded this cycle.
    This deduplicates held requests.
  - The head responds when its count reaches 0; at most one response per cycle.
  - A full FIFO ignores mem_req.
  - Enqueue and dequeue in the same cycle when full is allowed.
  - Write forwarding applies per entry at its registration edge.
- MEM_PIPELINE_EN undefined: the single-outstanding FSM above; PEND_DEPTH is unused.

Decomposition:
- Package mem_pkg:
  - LINE_BYTES, OFF_WIDTH, INDEX_WIDTH derivations.
  - resp_state_t enum {IDLE, WAIT, RESP}.
  - pend_entry_t struct {addr, count}.
- Sub-module mem_array: MEM_LINES x LINE_SIZE storage, synchronous write, combinational read, with the write-forward mux inside.

Test Plan:
- Reset: drive rst low mid-WAIT, release -> mem_res stays 0 for 20 cycles; outputs read 0.
- Latency: write line 0x1000=0xA5...A5; hold mem_req with addr 0x1004, accepted at edge 10 -> mem_res=1 only in the cycle after edge 15, mem_res_addr=0x1000, data=0xA5...A5; exactly one pulse.
- Forwarding:
  - Read 0x2000 while mem_write 0x2000=0x11...11 in the same IDLE cycle -> response 0x11...11.
  - Second write 0x22...22 at latency cycle 3 -> response 0x22...22.
- Wrap: write addr 0x0001_0000 (index 0 with MEM_LINES=4096, LINE_SIZE=128), read 0x0 -> same data.
- Held request: mem_req held high across RESP and dropped one cycle after mem_res -> no second response.
- MEM_PIPELINE_EN:
  - Four distinct reads on consecutive cycles -> four in-order responses on consecutive cycles starting MEM_LATENCY after the first.
  - A fifth read while full -> ignored until space frees.
